market_average: RTL and testbench
=================================

MARKET_AVERAGE -- requirements
Module: market_average

Interface
REQ-001 SHALL have parameter WINDOW_LOG2, default 3, log2 of the moving-average window depth (8 samples).
REQ-002 SHALL have parameter TRACKED_SYMBOL, default 32'h0, the symbol accepted when the filter is compiled in.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_i, input, 1, synchronous active-low reset.
REQ-005 SHALL have port message_i, input, 178, market message: [177:176] MsgType, [175:144] Symbol, [143:80] BidPx, [79:72] BidSize, [71:8] OfferPx, [7:0] OfferSize.
REQ-006 SHALL have port v_i, input, 1, message_i valid.
REQ-007 SHALL have port ready_o, output, 1, block can accept a message.
REQ-008 SHALL have port message_o, output, 178, registered copy of the accepted message.
REQ-009 SHALL have port average_o, output, 64, moving average of the window prior to this message.
REQ-010 SHALL have port v_o, output, 1, message_o/average_o valid.
REQ-011 SHALL have port yumi_i, input, 1, downstream consumes the output this cycle.

Function
REQ-012 SHALL run a three-state FSM: IDLE (ready_o=1), CALC, DONE (v_o=1).
REQ-013 SHALL move IDLE->CALC on v_i&ready_o, capturing message_i; v_i in other states is ignored.
REQ-014 SHALL move CALC->DONE unconditionally, so v_o rises exactly 2 cycles after the accepting edge.
REQ-015 SHALL move DONE->IDLE on yumi_i; message_o/average_o hold stable while v_o=1 and yumi_i=0.
REQ-016 SHALL take the price sample from BidPx for MsgType 2'b10 and from OfferPx for 2'b01; types 2'b00/2'b11 are pass-through with no window update.
REQ-017 SHALL compute average_o in CALC as running_sum >> WINDOW_LOG2 taken before the current sample is inserted.
REQ-018 SHALL, on the first price sample after reset (primed=0), prefill all entries with the sample, set running_sum = sample << WINDOW_LOG2, set primed=1, and output average_o = sample.
REQ-019 SHALL, when primed, update running_sum = running_sum - oldest + sample, overwrite the oldest entry, and advance the write index modulo 2^WINDOW_LOG2 (wrap from 7 to 0).
REQ-020 SHALL size running_sum at 64+WINDOW_LOG2 bits so no overflow occurs; average_o is the truncated low 64 bits of the shift.
REQ-021 SHALL output average_o = 0 for non-price messages received before primed, else the current window average.

Reset
REQ-022 SHALL, when reset_i=0 at a clock edge, force state IDLE, ready_o=1, v_o=0, message_o=0, average_o=0, running_sum=0, write index=0, primed=0, all window entries=0.
REQ-023 SHALL let reset in any state, including DONE with v_o=1, abandon the pending output without waiting for yumi_i.

Configuration
REQ-024 SHALL, with MARKET_AVG_SYMBOL_FILTER_EN defined, treat price messages whose Symbol != TRACKED_SYMBOL as pass-through with no window update and the current average.
REQ-025 SHALL, without MARKET_AVG_SYMBOL_FILTER_EN, use every price message regardless of Symbol; TRACKED_SYMBOL is unused.

Structure
REQ-026 SHALL take the message field bit positions, the MsgType encodings (NONE=00, OFFER=01, BID=10, CONFIRM=11) and the FSM state enum from the shared package hft_pkg.
REQ-027 SHALL place the circular sample buffer, write index, running sum and prefill logic in the sub-module avg_window, leaving the FSM and handshake in market_average.

Verification
REQ-028 SHALL cover: reset, then BID with BidPx=100 -> v_o 2 cycles after accept, average_o=100, message_o equals input.
REQ-029 SHALL cover: after REQ-028, OFFER messages with OfferPx=108, each consumed immediately -> averages 100, 101, 102, 103, 104, 105, 106, 107, then 108 on the 9th.
REQ-030 SHALL cover: CONFIRM with BidPx=500 after a window of 100s -> average_o=100, and the next BID of 100 also reports 100.
REQ-031 SHALL cover: yumi_i held 0 for 5 cycles in DONE while v_i=1 -> v_o=1, outputs stable, ready_o=0, no new capture.
REQ-032 SHALL cover: first BID with BidPx=64'hFFFF_FFFF_FFFF_FFFF, then a second one -> average_o=64'hFFFF_FFFF_FFFF_FFFF both times, no wrap.
REQ-033 SHALL cover: reset_i=0 while in DONE, then BID of 50 -> v_o drops next edge, primed cleared, and the BID of 50 reports average_o=50.

Source files
------------

// File: rtl/hft_pkg.sv
// Shared definitions for the market data averaging block:
// message field positions, message type encodings and FSM states.
package hft_pkg;

    localparam int MSG_W     = 178;
    localparam int PX_W      = 64;
    localparam int SYM_W     = 32;

    localparam int TYPE_LSB  = 176;
    localparam int SYM_LSB   = 144;
    localparam int BIDPX_LSB = 80;
    localparam int BIDSZ_LSB = 72;
    localparam int OFFPX_LSB = 8;
    localparam int OFFSZ_LSB = 0;

    typedef enum logic [1:0] {
        MSG_NONE    = 2'b00,
        MSG_OFFER   = 2'b01,
        MSG_BID     = 2'b10,
        MSG_CONFIRM = 2'b11
    } msg_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/avg_window.sv
// Circular price window with running sum and first-sample prefill.
// Ports: clk_i, reset_i (sync, active-low), upd_i (insert sample_i this
// cycle), sample_i, avg_o (average of the window before this insert).
module avg_window
    import hft_pkg::*;
#(
    parameter int WINDOW_LOG2 = 3
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            upd_i,
    input  logic [PX_W-1:0] sample_i,
    output logic [PX_W-1:0] avg_o
);

    localparam int N     = 1 << WINDOW_LOG2;
    localparam int SUM_W = PX_W + WINDOW_LOG2;

    logic [PX_W-1:0]        buf_q [N];
    logic [PX_W-1:0]        buf_d [N];
    logic [SUM_W-1:0]       sum_q, sum_d;
    logic [WINDOW_LOG2-1:0] idx_q, idx_d;
    logic                   primed_q, primed_d;

    always_comb begin
        buf_d    = buf_q;
        sum_d    = sum_q;
        idx_d    = idx_q;
        primed_d = primed_q;
        avg_o    = '0;
        if (primed_q) begin
            avg_o = sum_q[SUM_W-1:WINDOW_LOG2];
        end
        if (upd_i) begin
            if (!primed_q) begin
                // First sample fills the whole window so the average
                // starts at the sample instead of ramping up from zero.
                for (int i = 0; i < N; i++) begin
                    buf_d[i] = sample_i;
                end
                sum_d    = SUM_W'(sample_i) << WINDOW_LOG2;
                primed_d = 1'b1;
                avg_o    = sample_i;
            end else begin
                sum_d        = sum_q - SUM_W'(buf_q[idx_q])
                             + SUM_W'(sample_i);
                buf_d[idx_q] = sample_i;
                idx_d        = idx_q + WINDOW_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
            sum_q    <= '0;
            idx_q    <= '0;
            primed_q <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            sum_q    <= sum_d;
            idx_q    <= idx_d;
            primed_q <= primed_d;
        end
    end

endmodule

// File: rtl/market_average.sv
// Moving average of bid/offer prices over a market message stream.
// Ports: clk_i, reset_i (sync, active-low), message_i/v_i/ready_o in,
// message_o/average_o/v_o/yumi_i out. Optional symbol filter is enabled
// by defining MARKET_AVG_SYMBOL_FILTER_EN (matches TRACKED_SYMBOL).
module market_average
    import hft_pkg::*;
#(
    parameter int          WINDOW_LOG2    = 3,
    parameter logic [31:0] TRACKED_SYMBOL = 32'h0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [MSG_W-1:0] message_i,
    input  logic             v_i,
    output logic             ready_o,
    output logic [MSG_W-1:0] message_o,
    output logic [PX_W-1:0]  average_o,
    output logic             v_o,
    input  logic             yumi_i
);

    state_e           state_q, state_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic [PX_W-1:0]  avg_q, avg_d;

    msg_type_e        mtype;
    logic             is_px;
    logic             sym_ok;
    logic             upd;
    logic [PX_W-1:0]  sample;
    logic [PX_W-1:0]  win_avg;

    assign mtype = msg_type_e'(msg_q[TYPE_LSB +: 2]);

`ifdef MARKET_AVG_SYMBOL_FILTER_EN
    assign sym_ok = (msg_q[SYM_LSB +: SYM_W] == TRACKED_SYMBOL);
`else
    logic unused_sym;
    assign unused_sym = ^TRACKED_SYMBOL;
    assign sym_ok     = 1'b1;
`endif

    always_comb begin
        is_px  = 1'b0;
        sample = '0;
        unique case (mtype)
            MSG_BID: begin
                is_px  = 1'b1;
                sample = msg_q[BIDPX_LSB +: PX_W];
            end
            MSG_OFFER: begin
                is_px  = 1'b1;
                sample = msg_q[OFFPX_LSB +: PX_W];
            end
            default: begin
                is_px  = 1'b0;
                sample = '0;
            end
        endcase
    end

    assign upd = (state_q == ST_CALC) && is_px && sym_ok;

    avg_window #(
        .WINDOW_LOG2 (WINDOW_LOG2)
    ) u_window (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .upd_i    (upd),
        .sample_i (sample),
        .avg_o    (win_avg)
    );

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        avg_d   = avg_q;
        unique case (state_q)
            ST_IDLE: begin
                if (v_i) begin
                    state_d = ST_CALC;
                    msg_d   = message_i;
                end
            end
            ST_CALC: begin
                state_d = ST_DONE;
                avg_d   = win_avg;
            end
            ST_DONE: begin
                if (yumi_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            msg_q   <= '0;
            avg_q   <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            avg_q   <= avg_d;
        end
    end

    assign ready_o   = (state_q == ST_IDLE);
    assign v_o       = (state_q == ST_DONE);
    assign message_o = msg_q;
    assign average_o = avg_q;

endmodule

// File: tb/tb_market_average.sv
// Directed bench for market_average: latency, window averaging,
// pass-through types, backpressure, overflow headroom and reset.
module tb_market_average;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [177:0] message_i;
    logic         v_i;
    logic         ready_o;
    logic [177:0] message_o;
    logic [63:0]  average_o;
    logic         v_o;
    logic         yumi_i;

    int n_checks = 0;
    int n_fail   = 0;

    market_average dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .message_i (message_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .message_o (message_o),
        .average_o (average_o),
        .v_o       (v_o),
        .yumi_i    (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag,
                         input logic [177:0] obs,
                         input logic [177:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [177:0] mk(input logic [1:0] t,
                                        input logic [31:0] sym,
                                        input logic [63:0] bid,
                                        input logic [63:0] off);
        return {t, sym, bid, 8'h11, off, 8'h22};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        tick();
        tick();
        reset_i = 1'b1;
    endtask

    // Accept, check 2-cycle latency and results, then consume.
    task automatic txn(input string tag,
                       input logic [177:0] m,
                       input logic [63:0] exp_avg,
                       input bit consume);
        check({tag, "_rdy"}, 178'(ready_o), 178'(1));
        message_i = m;
        v_i       = 1'b1;
        tick();
        v_i = 1'b0;
        check({tag, "_lat1"}, 178'(v_o), 178'(0));
        tick();
        check({tag, "_vo"}, 178'(v_o), 178'(1));
        check({tag, "_avg"}, 178'(average_o), 178'(exp_avg));
        check({tag, "_msg"}, message_o, m);
        if (consume) begin
            yumi_i = 1'b1;
            tick();
            yumi_i = 1'b0;
        end
    endtask

    logic [177:0] m;
    logic [63:0]  avg_hold;

    initial begin
        reset_i   = 1'b0;
        message_i = '0;
        v_i       = 1'b0;
        yumi_i    = 1'b0;
        do_reset();
        check("rst_rdy", 178'(ready_o), 178'(1));
        check("rst_vo", 178'(v_o), 178'(0));
        check("rst_msg", message_o, 178'(0));
        check("rst_avg", 178'(average_o), 178'(0));

        // Non-price before any sample reports zero
        txn("pre_conf", mk(2'b11, 32'h5, 64'd77, 64'd88), 64'd0, 1);
        txn("pre_none", mk(2'b00, 32'h5, 64'd77, 64'd88), 64'd0, 1);

        // First BID primes window at 100
        txn("bid100", mk(2'b10, 32'hA, 64'd100, 64'd999), 64'd100, 1);

        // OFFERs of 108 ramp the average one step per sample
        for (int i = 0; i < 9; i++) begin
            txn($sformatf("off%0d", i),
                mk(2'b01, 32'hB, 64'd999, 64'd108),
                64'(100 + i), 1);
        end

        // Pass-through does not disturb the window
        do_reset();
        txn("w100", mk(2'b10, 32'h1, 64'd100, 64'd0), 64'd100, 1);
        txn("conf500", mk(2'b11, 32'h1, 64'd500, 64'd0), 64'd100, 1);
        txn("bid_after", mk(2'b10, 32'h1, 64'd100, 64'd0), 64'd100, 1);

        // Backpressure: hold in DONE with a new message offered
        txn("hold", mk(2'b10, 32'h2, 64'd100, 64'd0), 64'd100, 0);
        m        = message_o;
        avg_hold = average_o;
        message_i = mk(2'b10, 32'h3, 64'd9000, 64'd0);
        v_i       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold%0d_vo", i), 178'(v_o), 178'(1));
            check($sformatf("hold%0d_rdy", i), 178'(ready_o), 178'(0));
            check($sformatf("hold%0d_msg", i), message_o,
                  mk(2'b10, 32'h2, 64'd100, 64'd0));
            check($sformatf("hold%0d_avg", i), 178'(average_o),
                  178'(64'd100));
        end
        v_i    = 1'b0;
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        check("hold_rel_rdy", 178'(ready_o), 178'(1));
        check("hold_rel_vo", 178'(v_o), 178'(0));
        // Ignored 9000 never entered the window
        txn("hold_next", mk(2'b10, 32'h2, 64'd100, 64'd0), 64'd100, 1);

        // Maximum price: no wrap of the running sum
        do_reset();
        txn("max1", mk(2'b10, 32'h0, '1, 64'd0), '1, 1);
        txn("max2", mk(2'b10, 32'h0, '1, 64'd0), '1, 1);

        // Reset while in DONE abandons output and clears priming
        do_reset();
        txn("p200", mk(2'b10, 32'h0, 64'd200, 64'd0), 64'd200, 1);
        txn("d200", mk(2'b10, 32'h0, 64'd200, 64'd0), 64'd200, 0);
        reset_i = 1'b0;
        tick();
        check("rstd_vo", 178'(v_o), 178'(0));
        check("rstd_rdy", 178'(ready_o), 178'(1));
        check("rstd_msg", message_o, 178'(0));
        check("rstd_avg", 178'(average_o), 178'(0));
        reset_i = 1'b1;
        txn("bid50", mk(2'b10, 32'h0, 64'd50, 64'd0), 64'd50, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
